// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor reload and clean stop.
// Define CLKDIV_SYNC_EN to add sync_i, a global phase restart for all enabled channels.
module clk_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       load_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
`ifdef CLKDIV_SYNC_EN
  input  logic                    sync_i,
`endif
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick_out,
  output logic [NUM_CH-1:0]       pending_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  logic sync_s;

`ifdef CLKDIV_SYNC_EN
  assign sync_s = sync_i;
`else
  assign sync_s = 1'b0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           state_r;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] shadow_r;
    logic             pend_r;
    logic             clk_r;
    logic             tick_r;

    logic [DIV_W-1:0] eff_s;
    logic [DIV_W-1:0] high_s;
    logic [DIV_W-1:0] cnt_nxt_s;
    logic             wrap_s;
    logic             start_s;
    logic             stop_s;

    // Effective divisor, high time and period-boundary decode
    always_comb begin
      eff_s     = (div_r < DIV_MIN) ? DIV_MIN : div_r;
      high_s    = eff_s - (eff_s >> 1);
      cnt_nxt_s = cnt_r + CNT_ONE;
      wrap_s    = (state_r == ST_RUN) && (cnt_r == (eff_s - CNT_ONE));
      start_s   = en_i[c] && (sync_s || (state_r == ST_IDLE) || wrap_s);
      stop_s    = !en_i[c] && (sync_s || wrap_s);
    end

    // Period sequencer with shadowed divisor; a same-edge load lands after any apply
    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        state_r  <= ST_IDLE;
        cnt_r    <= {DIV_W{1'b0}};
        div_r    <= DIV_RST;
        shadow_r <= DIV_RST;
        pend_r   <= 1'b0;
        clk_r    <= 1'b0;
        tick_r   <= 1'b0;
      end else begin
        if (start_s) begin
          state_r <= ST_RUN;
          cnt_r   <= {DIV_W{1'b0}};
          clk_r   <= 1'b1;
          tick_r  <= 1'b1;
          if (pend_r) begin
            div_r  <= shadow_r;
            pend_r <= 1'b0;
          end else begin
            div_r  <= div_r;
          end
        end else if (stop_s) begin
          state_r <= ST_IDLE;
          cnt_r   <= {DIV_W{1'b0}};
          clk_r   <= 1'b0;
          tick_r  <= 1'b0;
        end else if (state_r == ST_RUN) begin
          cnt_r  <= cnt_nxt_s;
          clk_r  <= (cnt_nxt_s < high_s);
          tick_r <= 1'b0;
        end else begin
          cnt_r  <= {DIV_W{1'b0}};
          clk_r  <= 1'b0;
          tick_r <= 1'b0;
        end
        if (load_i[c]) begin
          shadow_r <= div_i[c*DIV_W +: DIV_W];
          pend_r   <= 1'b1;
        end else begin
          shadow_r <= shadow_r;
        end
      end
    end

    assign clk_out[c]   = clk_r;
    assign tick_out[c]  = tick_r;
    assign pending_o[c] = pend_r;
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench for clk_divider_multi: directed scenarios plus randomized traffic
// compared every cycle against a period-position reference model.
module tb_clk_divider_multi;

  localparam int NUM_CH      = 4;
  localparam int DIV_W       = 16;
  localparam int DEFAULT_DIV = 2;

  logic                    clk_in = 1'b0;
  logic                    reset  = 1'b0;
  logic [NUM_CH-1:0]       en_i   = '0;
  logic [NUM_CH-1:0]       load_i = '0;
  logic [NUM_CH*DIV_W-1:0] div_i  = '0;
  logic                    sync_i = 1'b0;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick_out;
  logic [NUM_CH-1:0]       pending_o;

  int n_chk  = 0;
  int n_fail = 0;

  clk_divider_multi #(
    .NUM_CH     (NUM_CH),
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .en_i     (en_i),
    .load_i   (load_i),
    .div_i    (div_i),
`ifdef CLKDIV_SYNC_EN
    .sync_i   (sync_i),
`endif
    .clk_out  (clk_out),
    .tick_out (tick_out),
    .pending_o(pending_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic set_div(input int ch, input int val);
    div_i[ch*DIV_W +: DIV_W] = DIV_W'(val);
  endtask

  // Waits for the period start that applies a load issued on the previous cycle
  task automatic wait_apply(input int ch);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!tick_out[ch] && k < 20);
    chk("apply_tick", 32'(tick_out[ch]), 32'd1);
    chk("apply_pend", 32'(pending_o[ch]), 32'd0);
  endtask

  // Reference model: each running channel is at position m_pos within a period of m_eff cycles
  int m_pos  [NUM_CH];
  bit m_run  [NUM_CH];
  int m_eff  [NUM_CH];
  int m_shd  [NUM_CH];
  bit m_pend [NUM_CH];
  logic [3*NUM_CH-1:0] exp_vec;

  function automatic int eff_of(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_run[c] = 1'b0; m_pos[c] = 0; m_eff[c] = DEFAULT_DIV;
        m_shd[c] = DEFAULT_DIV; m_pend[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (en_i[c] && (sync_i || !m_run[c] || m_pos[c] == m_eff[c] - 1)) begin
          m_run[c] = 1'b1;
          m_pos[c] = 0;
          if (m_pend[c]) begin
            m_eff[c]  = eff_of(m_shd[c]);
            m_pend[c] = 1'b0;
          end
        end else if (m_run[c] && (sync_i || m_pos[c] == m_eff[c] - 1)) begin
          m_run[c] = 1'b0;
          m_pos[c] = 0;
        end else if (m_run[c]) begin
          m_pos[c] = m_pos[c] + 1;
        end
        if (load_i[c]) begin
          m_shd[c]  = int'(div_i[c*DIV_W +: DIV_W]);
          m_pend[c] = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk_in) begin
    for (int c = 0; c < NUM_CH; c++) begin
      exp_vec[c]          = m_run[c] && (m_pos[c] < m_eff[c] - m_eff[c] / 2);
      exp_vec[NUM_CH+c]   = m_run[c] && (m_pos[c] == 0);
      exp_vec[2*NUM_CH+c] = m_pend[c];
    end
    chk("model_cmp", 32'({pending_o, tick_out, clk_out}), 32'(exp_vec));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_clk",  32'(clk_out),   32'd0);
    chk("rst_tick", 32'(tick_out),  32'd0);
    chk("rst_pend", 32'(pending_o), 32'd0);

    // Channel 0 at default divide-by-2
    en_i[0] = 1'b1;
    step();
    chk("ch0_first_clk",  32'(clk_out[0]),  32'd1);
    chk("ch0_first_tick", 32'(tick_out[0]), 32'd1);
    step();
    chk("ch0_low_clk",  32'(clk_out[0]),  32'd0);
    chk("ch0_low_tick", 32'(tick_out[0]), 32'd0);
    step();
    chk("ch0_second_tick", 32'(tick_out[0]), 32'd1);

    // Channel 1: load 5 while running at 2
    en_i[1] = 1'b1;
    repeat (3) step();
    set_div(1, 5);
    load_i[1] = 1'b1;
    step();
    load_i[1] = 1'b0;
    chk("div5_pend_set", 32'(pending_o[1]), 32'd1);
    wait_apply(1);
    for (int i = 0; i < 10; i++) begin
      chk("div5_clk",  32'(clk_out[1]),  32'((i % 5) < 3));
      chk("div5_tick", 32'(tick_out[1]), 32'((i % 5) == 0));
      step();
    end

    // Divisors 0 and 1 both behave as 2
    set_div(2, 0);
    set_div(3, 1);
    load_i[3:2] = 2'b11;
    step();
    load_i[3:2] = 2'b00;
    chk("div01_pend", 32'(pending_o[3:2]), 32'd3);
    en_i[3:2] = 2'b11;
    step();
    chk("div01_applied", 32'(pending_o[3:2]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("div01_clk", 32'(clk_out[3:2]), (i % 2 == 0) ? 32'd3 : 32'd0);
      step();
    end

    // Channel 0: N=8, drop enable at cnt=2
    set_div(0, 8);
    load_i[0] = 1'b1;
    step();
    load_i[0] = 1'b0;
    wait_apply(0);
    step();
    step();
    chk("n8_cnt2_clk", 32'(clk_out[0]), 32'd1);
    en_i[0] = 1'b0;
    for (int i = 3; i < 12; i++) begin
      step();
      chk("n8_stop_clk",  32'(clk_out[0]),  32'(i < 4));
      chk("n8_stop_tick", 32'(tick_out[0]), 32'd0);
    end

    // Channel 1: N=6, async reset at cnt=3; channel 0 holds a pending load
    set_div(1, 6);
    load_i[1] = 1'b1;
    step();
    load_i[1] = 1'b0;
    wait_apply(1);
    set_div(0, 3);
    load_i[0] = 1'b1;
    step();
    load_i[0] = 1'b0;
    step();
    step();
    chk("n6_cnt3_clk",  32'(clk_out[1]),   32'd0);
    chk("n6_pend0",     32'(pending_o[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_clk",  32'(clk_out),   32'd0);
    chk("async_rst_tick", 32'(tick_out),  32'd0);
    chk("async_rst_pend", 32'(pending_o), 32'd0);
    @(negedge clk_in);
    reset = 1'b0;
    step();
    chk("post_rst_tick", 32'(tick_out[1]), 32'd1);
    chk("post_rst_clk",  32'(clk_out[1]),  32'd1);
    step();
    chk("post_rst_default_div", 32'(clk_out[1]), 32'd0);

`ifdef CLKDIV_SYNC_EN
    // Channels at N=4 and N=6, offset, then realigned by sync_i
    en_i[1:0] = 2'b11;
    set_div(0, 4);
    set_div(1, 6);
    load_i[1:0] = 2'b11;
    step();
    load_i[1:0] = 2'b00;
    repeat (20 + $urandom_range(0, 3)) step();
    chk("sync_pend_clear", 32'(pending_o[1:0]), 32'd0);
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    chk("sync_tick", 32'(tick_out[1:0]), 32'd3);
    repeat (12) step();
    chk("sync_realign", 32'(tick_out[1:0]), 32'd3);
`endif

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        en_i[c]   = ($urandom_range(0, 15) != 0);
        load_i[c] = ($urandom_range(0, 7) == 0);
        set_div(c, $urandom_range(0, 9));
      end
`ifdef CLKDIV_SYNC_EN
      sync_i = ($urandom_range(0, 49) == 0);
`endif
      if (i == 1500) begin
        #2 reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
      end
      step();
    end
    load_i = '0;
    sync_i = 1'b0;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_divider_multi.md
# clk_divider_multi

Multi-channel programmable clock divider generating NUM_CH independent divided clock/strobe pairs from clk_in. Each channel has a runtime-loadable divisor applied glitch-free at period boundaries, plus a per-channel enable that stops the output cleanly at the end of a period. It replaces fixed single-ratio dividers feeding peripheral timing, baud and display-refresh logic.

## Interface
- NUM_CH, 4, number of independent channels
- DIV_W, 16, divisor width in bits
- DEFAULT_DIV, 2, divisor loaded into every channel at reset (must be ≥ 2)
- clk_in  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- en_i  input  NUM_CH  per-channel run enable
- load_i  input  NUM_CH  per-channel divisor load strobe
- div_i  input  NUM_CH*DIV_W  divisor values; channel c uses bits [c*DIV_W +: DIV_W]
- clk_out  output  NUM_CH  divided clocks, registered
- tick_out  output  NUM_CH  one-cycle pulse marking each period start
- pending_o  output  NUM_CH  loaded divisor not yet applied
- sync_i  input  1  global phase restart pulse (only with CLKDIV_SYNC_EN)

## Operation
- Per channel: state, DIV_W-bit counter cnt, active divisor N, shadow divisor S, pending flag.
- Effective divisor = max(N, 2); values 0 and 1 behave as 2.
- High time H = N − floor(N/2) (ceil); low time = floor(N/2). N=2: 1/1; N=3: 2/1; N=8: 4/4.
- States:
  - IDLE: cnt=0, clk_out=0, tick_out=0. If en_i=1, go to RUN: cnt←0, clk_out←1, tick_out←1, N←S if pending, pending cleared.
  - RUN, not at wrap (cnt≠N−1): cnt←cnt+1, clk_out←(cnt+1 < H), tick_out←0.
  - RUN, at wrap (cnt=N−1): if en_i=1, start a new period as for IDLE→RUN. If en_i=0, go to IDLE with clk_out←0, tick_out←0.
- en_i deassertion mid-period has no effect until the wrap, so there are no runt pulses.
- Load: load_i[c]=1 sets S←div_i slice and pending←1. A load while pending is set overwrites S.
- A load in the same cycle as a wrap does not affect that wrap. Apply uses pre-edge S/pending, so the new value takes effect at the following period start.
- Channels are fully independent; only sync_i couples them.

## Timing
- Reset values: clk_out=0, tick_out=0, pending_o=0, cnt=0, state=IDLE, N=S=DEFAULT_DIV.
- Reset is asynchronous; asserting it mid-period forces reset values immediately.
- Latency: en_i sampled high in IDLE at edge k gives clk_out=1 and tick_out=1 after edge k.
- Period is exactly N clk_in cycles. tick_out is high for the first cycle of every period and coincides with the clk_out rising edge.
- pending_o rises one cycle after the load_i edge and falls after the applying edge.

## Configuration
- CLKDIV_SYNC_EN defined:
  - sync_i port exists.
  - A sync_i pulse forces every channel with en_i=1 to start a new period on the next edge (cnt←0, clk_out←1, tick_out←1, pending divisor applied), regardless of its current cnt.
  - Channels with en_i=0 go to IDLE.
  - sync_i has priority over load_i apply timing but not over reset.
- CLKDIV_SYNC_EN undefined: no sync_i port, no restart logic. Channels phase only from their own enable.

## Test plan
- Reset, then en_i=1 on channel 0 with DEFAULT_DIV=2: clk_out[0] toggles every cycle, tick_out[0] pulses every 2 cycles, first pulse one edge after en_i.
- Load 5 on channel 1 while running at N=2: the current period completes. Next periods are 5 cycles, high 3 / low 2. pending_o[1] clears at the applying edge.
- Load 0 and load 1: both give period 2, high 1 / low 1.
- Drop en_i mid-period with N=8 at cnt=2: clk_out completes 4 high / 4 low, then holds 0. tick_out shows no further pulses.
- Assert reset at cnt=3 of N=6: all outputs 0 immediately. After release with en_i=1, the first tick_out arrives one edge later.
- With CLKDIV_SYNC_EN, channels at N=4 and N=6 offset in phase, pulse sync_i: both tick_out bits pulse on the same cycle, and channels realign every 12 cycles.
